// File: rtl/svc_sram_cmd_arb.sv
// Round-robin arbiter sharing one SRAM command port between two requesters.
// Read IDs are tracked in order so read data returns to its issuer.
module svc_sram_cmd_arb #(
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int SRAM_DATA_WIDTH = 16,
  parameter int SRAM_STRB_WIDTH = SRAM_DATA_WIDTH / 8,
  parameter int RD_DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       s0_cmd_valid,
  output logic                       s0_cmd_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0] s0_cmd_addr,
  input  logic                       s0_cmd_wr_en,
  input  logic [SRAM_DATA_WIDTH-1:0] s0_cmd_wr_data,
  input  logic [SRAM_STRB_WIDTH-1:0] s0_cmd_wr_strb,
  output logic                       s0_resp_rd_valid,
  input  logic                       s0_resp_rd_ready,
  output logic [SRAM_DATA_WIDTH-1:0] s0_resp_rd_data,

  input  logic                       s1_cmd_valid,
  output logic                       s1_cmd_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0] s1_cmd_addr,
  input  logic                       s1_cmd_wr_en,
  input  logic [SRAM_DATA_WIDTH-1:0] s1_cmd_wr_data,
  input  logic [SRAM_STRB_WIDTH-1:0] s1_cmd_wr_strb,
  output logic                       s1_resp_rd_valid,
  input  logic                       s1_resp_rd_ready,
  output logic [SRAM_DATA_WIDTH-1:0] s1_resp_rd_data,

  output logic                       m_cmd_valid,
  input  logic                       m_cmd_ready,
  output logic [SRAM_ADDR_WIDTH-1:0] m_cmd_addr,
  output logic                       m_cmd_wr_en,
  output logic [SRAM_DATA_WIDTH-1:0] m_cmd_wr_data,
  output logic [SRAM_STRB_WIDTH-1:0] m_cmd_wr_strb,
  input  logic                       m_resp_rd_valid,
  output logic                       m_resp_rd_ready,
  input  logic [SRAM_DATA_WIDTH-1:0] m_resp_rd_data
);

  localparam int AW = $clog2(RD_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RD_DEPTH);

  // state | meaning
  // IDLE  | no grant; arbitrate on any valid
  // GNT0  | requester 0 owns the command port until its handshake
  // GNT1  | requester 1 owns the command port until its handshake
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_ptr;
  logic          r_id [RD_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_gnt0, w_gnt1, w_gnt_valid, w_gnt_wr;
  logic w_full, w_empty, w_blocked, w_hs, w_push, w_pop, w_head;

  function automatic state_t f_arb(input logic ptr, input logic v0, input logic v1);
    if (!v0 && !v1) return IDLE;
    if (ptr) return v1 ? GNT1 : GNT0;
    return v0 ? GNT0 : GNT1;
  endfunction

  assign w_gnt0      = (r_state == GNT0);
  assign w_gnt1      = (r_state == GNT1);
  assign w_gnt_valid = (w_gnt0 & s0_cmd_valid) | (w_gnt1 & s1_cmd_valid);
  assign w_gnt_wr    = w_gnt1 ? s1_cmd_wr_en : s0_cmd_wr_en;

  // Full is judged on the registered count, so a same-cycle pop cannot free a slot.
  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_blocked = !w_gnt_wr && w_full;

  assign m_cmd_valid   = w_gnt_valid & !w_blocked;
  assign m_cmd_addr    = w_gnt1 ? s1_cmd_addr    : s0_cmd_addr;
  assign m_cmd_wr_en   = w_gnt_wr;
  assign m_cmd_wr_data = w_gnt1 ? s1_cmd_wr_data : s0_cmd_wr_data;
  assign m_cmd_wr_strb = w_gnt1 ? s1_cmd_wr_strb : s0_cmd_wr_strb;

  assign s0_cmd_ready = w_gnt0 & m_cmd_ready & !w_blocked;
  assign s1_cmd_ready = w_gnt1 & m_cmd_ready & !w_blocked;

  assign w_hs   = m_cmd_valid & m_cmd_ready;
  assign w_push = w_hs & !w_gnt_wr;

  assign w_head           = r_id[r_rptr];
  assign m_resp_rd_ready  = !w_empty & (w_head ? s1_resp_rd_ready : s0_resp_rd_ready);
  assign s0_resp_rd_valid = m_resp_rd_valid & !w_empty & !w_head;
  assign s1_resp_rd_valid = m_resp_rd_valid & !w_empty &  w_head;
  assign s0_resp_rd_data  = m_resp_rd_data;
  assign s1_resp_rd_data  = m_resp_rd_data;
  assign w_pop            = m_resp_rd_valid & m_resp_rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= f_arb(r_ptr, s0_cmd_valid, s1_cmd_valid);
        default: begin
          // Preference passes to the requester that was not just served.
          if (w_hs) begin
            r_ptr   <= w_gnt0;
            r_state <= f_arb(w_gnt0, s0_cmd_valid, s1_cmd_valid);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_id[r_wptr] <= w_gnt1;
  end

endmodule
